fpaa_prog_sequencer: RTL and testbench

FPAA_PROG_SEQUENCER -- requirements
Module: fpaa_prog_sequencer

---
 rtl/fpaa_prog_pkg.sv | 22 ++
 rtl/fpaa_prog_timer.sv | 36 +++
 rtl/fpaa_prog_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fpaa_prog_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpaa_prog_pkg.sv
// Shared types and default sizing for the FPAA floating-gate programming sequencer.
package fpaa_prog_pkg;

   localparam int ROW_BITS_DEF = 5;
   localparam int COL_BITS_DEF = 6;
   localparam int PW_BITS_DEF  = 16;
   localparam int SETTLE_DEF   = 4;
   localparam int HOLD_DEF     = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      PULSE   = 2'd2,
      RECOVER = 2'd3
   } state_e;

   typedef enum logic {
      OP_INJ = 1'b0,
      OP_TUN = 1'b1
   } op_e;

endpackage

// File: rtl/fpaa_prog_timer.sv
// Loadable down-counter with zero flag; one instance times every phase of a command.
// The count stops at zero, so a full-scale load runs to completion without wrapping.
module fpaa_prog_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // load has priority; otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // counter register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpaa_prog_sequencer.sv
// Programming sequencer for an FPAA floating-gate array: decodes one row/column,
// settles the address, fires a VINJ or VTUN pulse, recovers, then reports done.
// Optional feature macro: FPAA_PROG_ABORT_EN adds the abort input.
//
// state   | meaning
// IDLE    | run mode, ready for a command; first IDLE cycle after a command pulses done
// SETUP   | address decoded in program mode, rails off, SETTLE cycles
// PULSE   | selected rail on for cmd_pulse cycles (skipped when cmd_pulse is 0)
// RECOVER | rails off, program mode held for HOLD cycles
module fpaa_prog_sequencer
   import fpaa_prog_pkg::*;
#(
   parameter int ROW_BITS = ROW_BITS_DEF,
   parameter int COL_BITS = COL_BITS_DEF,
   parameter int PW_BITS  = PW_BITS_DEF,
   parameter int SETTLE   = SETTLE_DEF,
   parameter int HOLD     = HOLD_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ROW_BITS-1:0] cmd_row,
   input  logic [COL_BITS-1:0] cmd_col,
   input  logic                cmd_op,
   input  logic [PW_BITS-1:0]  cmd_pulse,
`ifdef FPAA_PROG_ABORT_EN
   input  logic                abort,
`endif
   output logic [ROW_BITS-1:0] row_addr,
   output logic [COL_BITS-1:0] col_addr,
   output logic                dec_en,
   output logic                prog_r,
   output logic                run_r,
   output logic                vinj_en,
   output logic                vtun_en,
   output logic                drain_sel,
   output logic                busy,
   output logic                done
);

   state_e               state_q, state_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [COL_BITS-1:0]  col_q, col_d;
   op_e                  op_q, op_d;
   logic [PW_BITS-1:0]   pulse_q, pulse_d;
   logic                 done_d;
   logic                 tmr_load;
   logic [PW_BITS-1:0]   tmr_val;
   logic                 tmr_zero;

   logic                 ready_q, busy_q, done_q;
   logic                 dec_en_q, prog_r_q, run_r_q, drain_q;
   logic                 vinj_q, vtun_q;

   fpaa_prog_timer #(.W(PW_BITS)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Phase sequencing. The timer is loaded with (phase length - 1) on entry,
   // so a phase ends on the cycle the zero flag is seen.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      op_d     = op_q;
      pulse_d  = pulse_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d  = SETUP;
               row_d    = cmd_row;
               col_d    = cmd_col;
               op_d     = op_e'(cmd_op);
               pulse_d  = cmd_pulse;
               tmr_load = 1'b1;
               tmr_val  = PW_BITS'(SETTLE - 1);
            end
         end
         SETUP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (pulse_q == '0) begin
                  state_d = RECOVER;
                  tmr_val = PW_BITS'(HOLD - 1);
               end else begin
                  state_d = PULSE;
                  tmr_val = pulse_q - 1'b1;
               end
            end
         end
         PULSE: begin
            if (tmr_zero) begin
               state_d  = RECOVER;
               tmr_load = 1'b1;
               tmr_val  = PW_BITS'(HOLD - 1);
            end
         end
         RECOVER: begin
            if (tmr_zero) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef FPAA_PROG_ABORT_EN
      if (abort && ((state_q == SETUP) || (state_q == PULSE))) begin
         state_d  = RECOVER;
         tmr_load = 1'b1;
         tmr_val  = PW_BITS'(HOLD - 1);
      end
`endif
   end

   // State, command latch and registered outputs, all decoded from next state
   // so every output lines up with the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         op_q     <= OP_INJ;
         pulse_q  <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dec_en_q <= 1'b0;
         prog_r_q <= 1'b0;
         run_r_q  <= 1'b1;
         drain_q  <= 1'b0;
         vinj_q   <= 1'b0;
         vtun_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         op_q     <= op_d;
         pulse_q  <= pulse_d;
         ready_q  <= (state_d == IDLE);
         busy_q   <= (state_d != IDLE);
         done_q   <= done_d;
         dec_en_q <= (state_d != IDLE);
         prog_r_q <= (state_d != IDLE);
         run_r_q  <= (state_d == IDLE);
         drain_q  <= (state_d != IDLE);
         vinj_q   <= (state_d == PULSE) && (op_d == OP_INJ);
         vtun_q   <= (state_d == PULSE) && (op_d == OP_TUN);
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign row_addr  = row_q;
   assign col_addr  = col_q;
   assign dec_en    = dec_en_q;
   assign prog_r    = prog_r_q;
   assign run_r     = run_r_q;
   assign drain_sel = drain_q;
   assign vinj_en   = vinj_q;
   assign vtun_en   = vtun_q;

endmodule

// File: tb/tb_fpaa_prog_sequencer.sv
// Directed bench for fpaa_prog_sequencer (default sizing: SETTLE=4, HOLD=2).
// Build with FPAA_PROG_ABORT_EN defined to include the abort sequence.
module tb_fpaa_prog_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_row;
   logic [5:0]  cmd_col;
   logic        cmd_op;
   logic [15:0] cmd_pulse;
`ifdef FPAA_PROG_ABORT_EN
   logic        abort;
`endif
   logic [4:0]  row_addr;
   logic [5:0]  col_addr;
   logic        dec_en, prog_r, run_r, vinj_en, vtun_en, drain_sel, busy, done;

   int total = 0;
   int bad   = 0;

   fpaa_prog_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .cmd_op    (cmd_op),
      .cmd_pulse (cmd_pulse),
`ifdef FPAA_PROG_ABORT_EN
      .abort     (abort),
`endif
      .row_addr  (row_addr),
      .col_addr  (col_addr),
      .dec_en    (dec_en),
      .prog_r    (prog_r),
      .run_r     (run_r),
      .vinj_en   (vinj_en),
      .vtun_en   (vtun_en),
      .drain_sel (drain_sel),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  row;
      logic [5:0]  col;
      logic        op;
      logic [15:0] pulse;
      int          lat;
      int          nvinj;
      int          nvtun;
      int          ndec;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // idle output set, checked after reset and in done cycles
   task automatic chk_idle(input string tag);
      chk({tag, " ready"}, int'(cmd_ready), 1);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " ctl"}, int'({run_r, prog_r, dec_en, drain_sel, vinj_en, vtun_en}), 32);
   endtask

   // Issue one command from IDLE and follow it to done. Cycle 1 is the first
   // cycle after the accepting edge; returns with lat = cycle in which done is seen.
   task automatic run_cmd(input vec_t v, output int lat, output int nvinj,
                          output int nvtun, output int ndec, output int bad_cyc);
      lat = 0; nvinj = 0; nvtun = 0; ndec = 0; bad_cyc = 0;
      cmd_row = v.row; cmd_col = v.col; cmd_op = v.op; cmd_pulse = v.pulse;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 70000) begin
         if (vinj_en) nvinj++;
         if (vtun_en) nvtun++;
         if (dec_en)  ndec++;
         if (row_addr != v.row || col_addr != v.col) bad_cyc++;
         if (vinj_en && vtun_en) bad_cyc++;
         if (!(prog_r && drain_sel && !run_r && busy && !cmd_ready)) bad_cyc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, nvinj, nvtun, ndec, bc;
      vec_t a, b;

      vecs[0] = '{5'd3,  6'd17, 1'b0, 16'd10,    17,    10,    0, 16};
      vecs[1] = '{5'd5,  6'd40, 1'b1, 16'd0,     7,     0,     0, 6};
      vecs[2] = '{5'd31, 6'd63, 1'b1, 16'd3,     10,    0,     3, 9};
      vecs[3] = '{5'd0,  6'd0,  1'b0, 16'd1,     8,     1,     0, 7};
      vecs[4] = '{5'd7,  6'd9,  1'b0, 16'hFFFF,  65542, 65535, 0, 65541};

      cmd_valid = 1'b0; cmd_row = '0; cmd_col = '0; cmd_op = 1'b0; cmd_pulse = '0;
`ifdef FPAA_PROG_ABORT_EN
      abort = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      chk("reset done", int'(done), 0);
      chk("reset addr", int'({row_addr, col_addr}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         chk($sformatf("v%0d ready", i), int'(cmd_ready), 1);
         run_cmd(vecs[i], lat, nvinj, nvtun, ndec, bc);
         chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d vinj cycles", i), nvinj, vecs[i].nvinj);
         chk($sformatf("v%0d vtun cycles", i), nvtun, vecs[i].nvtun);
         chk($sformatf("v%0d dec cycles", i), ndec, vecs[i].ndec);
         chk($sformatf("v%0d bad cycles", i), bc, 0);
         chk($sformatf("v%0d done", i), int'(done), 1);
         chk_idle($sformatf("v%0d done-cycle", i));
         @(posedge clk); #1;
         chk($sformatf("v%0d done width", i), int'(done), 0);
      end

      // back-to-back: cmd_valid held high, second command taken in the done cycle
      a = '{5'd2, 6'd5,  1'b1, 16'd3, 10, 0, 3, 9};
      b = '{5'd9, 6'd33, 1'b0, 16'd2, 9,  2, 0, 8};
      cmd_row = a.row; cmd_col = a.col; cmd_op = a.op; cmd_pulse = a.pulse;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      lat = 1; bc = 0;
      while (!done && lat < 100) begin
         if (row_addr != a.row || col_addr != a.col) bc++;
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b A latency", lat, a.lat);
      chk("b2b A addr stable", bc, 0);
      chk("b2b done-cycle addr", int'({row_addr, col_addr}), int'({a.row, a.col}));
      chk("b2b done-cycle ready", int'(cmd_ready), 1);
      cmd_row = b.row; cmd_col = b.col; cmd_op = b.op; cmd_pulse = b.pulse;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("b2b B addr", int'({row_addr, col_addr}), int'({b.row, b.col}));
      chk("b2b B busy", int'(busy), 1);
      chk("b2b B done cleared", int'(done), 0);
      lat = 1; nvinj = 0;
      while (!done && lat < 100) begin
         if (vinj_en) nvinj++;
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b B latency", lat, b.lat);
      chk("b2b B vinj cycles", nvinj, b.nvinj);
      @(posedge clk); #1;

      // asynchronous reset in the 5th PULSE cycle (cycle 9 of a 10-cycle inject)
      cmd_row = 5'd12; cmd_col = 6'd44; cmd_op = 1'b0; cmd_pulse = 16'd10;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("rst-mid vinj before", int'(vinj_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst-mid vinj", int'(vinj_en), 0);
      chk("rst-mid run_r", int'(run_r), 1);
      chk("rst-mid busy", int'(busy), 0);
      chk("rst-mid addr", int'({row_addr, col_addr}), 0);
      chk_idle("rst-mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-rst ready", int'(cmd_ready), 1);
      chk("post-rst done", int'(done), 0);
      run_cmd(vecs[3], lat, nvinj, nvtun, ndec, bc);
      chk("post-rst latency", lat, vecs[3].lat);
      chk("post-rst vinj cycles", nvinj, vecs[3].nvinj);
      @(posedge clk); #1;

`ifdef FPAA_PROG_ABORT_EN
      // abort in PULSE cycle 3 of 100 (cycle 7 after acceptance)
      cmd_row = 5'd4; cmd_col = 6'd8; cmd_op = 1'b0; cmd_pulse = 16'd100;
      cmd_valid = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort = 1'b0;
      chk("abort ignored in IDLE", int'(busy), 1);
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("abort vinj before", int'(vinj_en), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort vinj after", int'(vinj_en), 0);
      chk("abort dec_en held", int'(dec_en), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort recover done", int'(done), 0);
      @(posedge clk); #1;
      chk("abort done", int'(done), 1);
      @(posedge clk); #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
